// File: rtl/decode_sequencer.sv
// Decode sequencer: 2-entry in-order instruction buffer with immediate-format decode and load-use bubbles.
// Latency: push-to-issue 1 cycle minimum, issue is combinational from head; backpressure via ex_ready_i holds head, if_ready_o drops when full or flushing.
module decode_sequencer #(
    parameter int DATA_WIDTH       = 32,
    parameter int LOAD_USE_BUBBLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_valid_i,
    input  logic [DATA_WIDTH-1:0] if_instr_i,
    input  logic [DATA_WIDTH-1:0] if_pc_i,
    output logic                  if_ready_o,
    input  logic                  flush_i,
    input  logic                  ex_ready_i,
    output logic                  id_valid_o,
    output logic [DATA_WIDTH-1:0] id_instr_o,
    output logic [DATA_WIDTH-1:0] id_pc_o,
    output logic [2:0]            id_imm_sel_o,
    output logic                  id_illegal_o
);

    localparam logic [2:0] IMM_NONE = 3'd0;
    localparam logic [2:0] IMM_I    = 3'd1;
    localparam logic [2:0] IMM_S    = 3'd2;
    localparam logic [2:0] IMM_B    = 3'd3;
    localparam logic [2:0] IMM_U    = 3'd4;
    localparam logic [2:0] IMM_J    = 3'd5;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic       ST_RUN   = 1'b0;
    localparam logic       ST_STALL = 1'b1;
    localparam logic [1:0] BUB_LOAD = 2'(LOAD_USE_BUBBLES - 1);

    logic [DATA_WIDTH-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [DATA_WIDTH-1:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [1:0]            count_q, count_d;
    logic                  arm_q, arm_d;
    logic [4:0]            rd_q, rd_d;
    logic [1:0]            bub_q, bub_d;

    logic       state;
    logic [6:0] opcode;
    logic [4:0] rs1, rs2, head_rd;
    logic [2:0] imm_raw;
    logic       illegal_raw, uses_rs1, uses_rs2;
    logic       hazard, push, pop, wr_idx;

    assign state   = (bub_q != 2'd0) ? ST_STALL : ST_RUN;
    assign opcode  = instr0_q[6:0];
    assign head_rd = instr0_q[11:7];
    assign rs1     = instr0_q[19:15];
    assign rs2     = instr0_q[24:20];

    // Illegal opcodes leave uses_rs1/uses_rs2 clear so they never raise a hazard.
    always_comb begin
        imm_raw     = IMM_NONE;
        illegal_raw = 1'b0;
        uses_rs1    = 1'b0;
        uses_rs2    = 1'b0;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: begin imm_raw = IMM_I; uses_rs1 = 1'b1; end
            OP_STORE:  begin imm_raw = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_BRANCH: begin imm_raw = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_LUI, OP_AUIPC: imm_raw = IMM_U;
            OP_JAL:    imm_raw = IMM_J;
            OP_REG:    begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
            OP_SYSTEM, OP_FENCE: imm_raw = IMM_NONE;
            default:   illegal_raw = 1'b1;
        endcase
    end

    assign hazard = arm_q && (count_q != 2'd0) &&
                    ((uses_rs1 && (rs1 != 5'd0) && (rs1 == rd_q)) ||
                     (uses_rs2 && (rs2 != 5'd0) && (rs2 == rd_q)));

    assign if_ready_o   = !rst_n || ((count_q < 2'd2) && !flush_i);
    assign push         = if_valid_i && (count_q < 2'd2) && !flush_i;
    assign id_valid_o   = (count_q != 2'd0) && !hazard && (state == ST_RUN) && !flush_i;
    assign pop          = id_valid_o && ex_ready_i;
    assign id_instr_o   = instr0_q;
    assign id_pc_o      = pc0_q;
    assign id_imm_sel_o = id_valid_o ? imm_raw : IMM_NONE;
    assign id_illegal_o = id_valid_o && illegal_raw;
    assign wr_idx       = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

    always_comb begin
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        count_d  = count_q;
        arm_d    = arm_q;
        rd_d     = rd_q;
        bub_d    = bub_q;
        if (flush_i) begin
            count_d = 2'd0;
            arm_d   = 1'b0;
            bub_d   = 2'd0;
        end else begin
            if (state == ST_STALL) begin
                bub_d = bub_q - 2'd1;
            end else if (hazard) begin
                arm_d = 1'b0;
                bub_d = BUB_LOAD;
            end
            if (pop) begin
                instr0_d = instr1_q;
                pc0_d    = pc1_q;
                if ((opcode == OP_LOAD) && (head_rd != 5'd0)) begin
                    arm_d = 1'b1;
                    rd_d  = head_rd;
                end else begin
                    arm_d = 1'b0;
                end
            end
            if (push) begin
                if (wr_idx) begin
                    instr1_d = if_instr_i;
                    pc1_d    = if_pc_i;
                end else begin
                    instr0_d = if_instr_i;
                    pc0_d    = if_pc_i;
                end
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            count_q  <= 2'd0;
            arm_q    <= 1'b0;
            rd_q     <= 5'd0;
            bub_q    <= 2'd0;
        end else begin
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
            count_q  <= count_d;
            arm_q    <= arm_d;
            rd_q     <= rd_d;
            bub_q    <= bub_d;
        end
    end

endmodule

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction/PC width from defines package.
REQ-002 Parameter LOAD_USE_BUBBLES, default 1, bubbles inserted on load-use hazard (legal 1..3).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 if_valid_i  input  1  fetch offers instruction.
REQ-006 if_instr_i  input  DATA_WIDTH  offered instruction.
REQ-007 if_pc_i  input  DATA_WIDTH  PC of offered instruction.
REQ-008 if_ready_o  output  1  sequencer accepts this cycle.
REQ-009 flush_i  input  1  redirect; kill all buffered work.
REQ-010 ex_ready_i  input  1  execute stage accepts.
REQ-011 id_valid_o  output  1  head instruction issued to execute.
REQ-012 id_instr_o  output  DATA_WIDTH  head instruction word.
REQ-013 id_pc_o  output  DATA_WIDTH  head PC.
REQ-014 id_imm_sel_o  output  3  immediate format select: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
REQ-015 id_illegal_o  output  1  head opcode unrecognised.

Function
REQ-016 SHALL hold a 2-entry in-order FIFO of {instr, pc}; count 0..2.
REQ-017 if_ready_o SHALL equal (count<2) AND NOT flush_i; push on if_valid_i AND if_ready_o.
REQ-018 Full FIFO SHALL not accept even if a pop occurs same cycle; push and pop simultaneously at count 1 keeps count 1.
REQ-019 id_instr_o/id_pc_o SHALL be driven combinationally from FIFO head (zero added latency; push-to-issue minimum 1 cycle).
REQ-020 Pop SHALL occur on id_valid_o AND ex_ready_i; while ex_ready_i=0 head and all id_* outputs SHALL hold stable.
REQ-021 Immediate select from opcode [6:0]: 0010011/0000011/1100111 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 0110011/1110011/0001111 -> NONE.
REQ-022 Any other opcode SHALL give id_imm_sel_o=NONE, id_illegal_o=1; instruction issues normally.
REQ-023 id_imm_sel_o and id_illegal_o SHALL be 0 whenever id_valid_o=0.
REQ-024 On pop of a load (opcode 0000011) with rd[11:7]!=0, SHALL record rd and set arm flag; any other pop SHALL clear arm.
REQ-025 Hazard: arm=1, count>0, head reads nonzero rs1[19:15] (formats I,S,B,R) or rs2[24:20] (S,B,R) equal to recorded rd.
REQ-026 States RUN (bubble counter=0) and STALL (counter!=0).
REQ-027 RUN with hazard: id_valid_o=0 that cycle, arm cleared, counter loaded LOAD_USE_BUBBLES-1 (STALL if nonzero, else stay RUN).
REQ-028 STALL: id_valid_o=0, counter decrements each cycle, -> RUN at 0; pushes still accepted.
REQ-029 Total bubbles per hazard SHALL equal LOAD_USE_BUBBLES exactly; hazard cannot retrigger for same load.
REQ-030 id_valid_o SHALL equal count>0 AND no hazard AND RUN AND NOT flush_i.
REQ-031 flush_i SHALL block push and pop that cycle; next cycle count=0, arm=0, counter=0, state RUN; flush overrides push/pop/hazard/stall.
REQ-032 Illegal instructions SHALL not participate in hazard detection.

Reset
REQ-033 rst_n low SHALL immediately clear count, arm, recorded rd, counter, state RUN, FIFO storage to 0.
REQ-034 During reset: id_valid_o=0, id_instr_o=0, id_pc_o=0, id_imm_sel_o=0, id_illegal_o=0, if_ready_o=1 (no push takes effect until rst_n high).
REQ-035 Reset asserted mid-stall or mid-transfer SHALL discard all state; first post-reset cycle behaves as empty RUN.

Verification
REQ-036 Push 0x00500093 (addi) pc 0x0, ex_ready_i=1 -> next cycle id_valid_o=1, id_imm_sel_o=1, id_pc_o=0x0; popped.
REQ-037 Push lw x5 (0x0002A283) then add x6,x5,x1 (0x00128333), LOAD_USE_BUBBLES=2 -> lw issues, then exactly 2 cycles id_valid_o=0, then add issues.
REQ-038 lw x0 followed by dependent-on-x0 instruction -> no bubble.
REQ-039 Fill FIFO (2 pushes, ex_ready_i=0) -> if_ready_o=0; third offer held; ex_ready_i=1 -> order preserved pc0, pc1, pc2.
REQ-040 flush_i during STALL with count=2 -> next cycle id_valid_o=0, if_ready_o=1, count=0; subsequent push issues without bubble.
REQ-041 Push opcode 0x0000007F -> id_valid_o=1, id_illegal_o=1, id_imm_sel_o=0; rst_n low mid-stream -> all outputs 0 asynchronously.
